capture_readback: RTL and testbench
===================================

Name: capture_readback

Overview:
- Upstream producer for the data-dump state machine: walks the circular capture RAM after a capture completes.
- Reads one sample per request through the RAM's synchronous read port.
- Presents each sample on a one-entry output register using the has_return_data / get_return_data handshake.
- The 32-bit word is split by the consumer into lower and upper 16-bit halves.

Parameters:
- ADDR_W, 10, capture RAM address width; depth = 2^ADDR_W samples.
- DATA_W, 32, sample width. Must be even; the consumer loads DATA_W/2 halves.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse from the capture controller; begin readback
- abort  in  1  one-cycle pulse; cancel readback
- start_addr  in  ADDR_W  first sample address (oldest sample in the ring)
- sample_count  in  ADDR_W+1  number of samples to return, 0..2^ADDR_W
- ram_rd_en  out  1  RAM read enable
- ram_rd_addr  out  ADDR_W  RAM read address
- ram_rd_data  in  DATA_W  RAM read data, valid the cycle after ram_rd_en
- get_return_data  in  1  consumer request level (held while consumer waits)
- has_return_data  out  1  return_data holds an unconsumed sample
- return_data  out  DATA_W  sample to consumer
- readback_idle  out  1  block idle; gates the consumer's first dump
- readback_done  out  1  one-cycle pulse after the last sample is consumed

Behaviour:
- Reset (reset_n=0 at clk edge) wins over all inputs. Reset values:
  - state=IDLE
  - ram_rd_en=0, ram_rd_addr=0, has_return_data=0, return_data=0, readback_done=0
  - readback_idle=1, remaining=0
- States: IDLE, FETCH, CAPTURE, PRESENT, HOLD. All outputs are registered or decoded from state only.
- IDLE:
  - readback_idle=1.
  - On start: latch addr=start_addr and remaining=sample_count.
  - If sample_count==0: stay IDLE and pulse readback_done next cycle.
  - Otherwise go to FETCH.
- FETCH: ram_rd_en=1, ram_rd_addr=addr. Go to CAPTURE.
- CAPTURE:
  - return_data<=ram_rd_data.
  - addr<=addr+1 modulo 2^ADDR_W (2^ADDR_W-1 wraps to 0).
  - remaining<=remaining-1.
  - Go to PRESENT.
- PRESENT:
  - has_return_data=1.
  - Pop occurs on the cycle get_return_data=1 && has_return_data=1; go to HOLD.
- HOLD:
  - has_return_data=0; return_data stays stable so the consumer can load it this cycle.
  - If remaining==0: go to IDLE and pulse readback_done for one cycle.
  - Otherwise go to FETCH.
- Latency:
  - start sampled at cycle 0 → has_return_data=1 at cycle 3.
  - Pop at cycle N → next has_return_data=1 at cycle N+4.
- return_data changes only in CAPTURE. It never changes while has_return_data=1, nor in the cycle after a pop.
- start is ignored outside IDLE.
- abort from any state: go to IDLE next cycle; has_return_data=0, ram_rd_en=0, no readback_done. return_data keeps its last value.
- abort and start in the same cycle: abort wins; the block stays IDLE.
- get_return_data while has_return_data=0: no effect.
- sample_count=2^ADDR_W: every RAM location is read exactly once, starting at start_addr and wrapping.

Decomposition:
- Shared package capture_pkg:
  - state encoding localparams for IDLE/FETCH/CAPTURE/PRESENT/HOLD
  - default ADDR_W/DATA_W constants, shared with the dump FSM and capture writer
- One sub-module: readback_addr_ctr.
  - Wrapping ADDR_W address register plus ADDR_W+1 remaining down-counter.
  - Controls: load, step; output: zero flag.

Test Plan:
- start_addr=0x005, sample_count=3; consumer pops immediately → RAM reads at 0x005, 0x006, 0x007.
  - has_return_data rises at cycle 3 after start.
  - readback_done pulses exactly once, one cycle after the third pop's HOLD.
- start_addr=0x3FE, sample_count=4 (ADDR_W=10) → reads 0x3FE, 0x3FF, 0x000, 0x001 in order.
- Consumer delays the request 20 cycles with RAM pattern data=addr*0x00010001 → has_return_data held high and return_data stable throughout.
  - return_data still equals the presented value in the cycle after the pop.
- sample_count=0 → no ram_rd_en; readback_done pulses one cycle after start; readback_idle stays 1.
- abort in PRESENT with 5 samples remaining → IDLE next cycle, has_return_data=0, no readback_done.
  - A new start then reads from its new start_addr.
- reset_n=0 for one cycle mid-HOLD → all outputs at reset values next cycle.
  - A start arriving during reset is ignored.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared types and sizes for the capture path:
// readback state encoding and default RAM geometry.
package capture_pkg;

  localparam int CAP_ADDR_W = 10;
  localparam int CAP_DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_PRESENT = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

endpackage

// File: rtl/capture_readback_if.sv
// RAM read port plus return-data handshake.
// master: readback block; slave: RAM + consumer.
interface capture_readback_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic              get_return_data;
  logic              has_return_data;
  logic [DATA_W-1:0] return_data;

  modport master (
    output ram_rd_en,
    output ram_rd_addr,
    input  ram_rd_data,
    input  get_return_data,
    output has_return_data,
    output return_data
  );

  modport slave (
    input  ram_rd_en,
    input  ram_rd_addr,
    output ram_rd_data,
    output get_return_data,
    input  has_return_data,
    input  return_data
  );
endinterface

// File: rtl/capture_readback_addr_ctr.sv
// Wrapping ring address plus remaining-sample counter.
// Ports: load/step controls, start addr/count in, addr/zero out.
module readback_addr_ctr #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [ADDR_W:0]   i_count,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_zero
);
  localparam logic [ADDR_W-1:0] A_ONE =
    {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] R_ONE =
    {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_rem;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr <= '0;
      r_rem  <= '0;
    end else if (i_load) begin
      r_addr <= i_start_addr;
      r_rem  <= i_count;
    end else if (i_step) begin
      // natural overflow gives the ring wrap
      r_addr <= r_addr + A_ONE;
      r_rem  <= r_rem - R_ONE;
    end
  end

  assign o_addr = r_addr;
  assign o_zero = (r_rem == '0);
endmodule

// File: rtl/capture_readback.sv
// Walks the capture ring, one sample per consumer pop.
// Ports: start/abort/start_addr/sample_count, bus, idle/done.
module capture_readback
  import capture_pkg::*;
#(
  parameter int ADDR_W = CAP_ADDR_W,
  parameter int DATA_W = CAP_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [ADDR_W:0]   i_sample_count,
  capture_readback_if.master bus,
  output logic              o_readback_idle,
  output logic              o_readback_done
);
  state_t            r_state;
  logic [DATA_W-1:0] r_data;
  logic              r_done;
  logic              w_load;
  logic              w_step;
  logic              w_zero;
  logic [ADDR_W-1:0] w_addr;

  assign w_load = (r_state == S_IDLE)
                & i_start & ~i_abort;
  assign w_step = (r_state == S_CAPTURE)
                & ~i_abort;

  readback_addr_ctr #(.ADDR_W(ADDR_W)) u_ctr (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_load       (w_load),
    .i_step       (w_step),
    .i_start_addr (i_start_addr),
    .i_count      (i_sample_count),
    .o_addr       (w_addr),
    .o_zero       (w_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else if (i_abort) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_sample_count == '0)
              r_done <= 1'b1;
            else
              r_state <= S_FETCH;
          end
        end
        S_FETCH:   r_state <= S_CAPTURE;
        S_CAPTURE: begin
          r_data  <= bus.ram_rd_data;
          r_state <= S_PRESENT;
        end
        S_PRESENT: begin
          if (bus.get_return_data)
            r_state <= S_HOLD;
        end
        S_HOLD: begin
          // counter already stepped in CAPTURE
          if (w_zero) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ram_rd_en       = (r_state == S_FETCH);
  assign bus.ram_rd_addr     = w_addr;
  assign bus.has_return_data = (r_state == S_PRESENT);
  assign bus.return_data     = r_data;
  assign o_readback_idle     = (r_state == S_IDLE);
  assign o_readback_done     = r_done;
endmodule

// File: tb/tb_capture_readback.sv
// Directed + random bench for capture_readback.
// Ring RAM model, expected samples from address arithmetic.
module tb_capture_readback;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   sample_count = '0;
  logic          idle;
  logic          done;

  int n_assert = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int rd_q[$];
  logic [DW-1:0] mem [DEPTH];

  capture_readback_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  capture_readback #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_start        (start),
    .i_abort        (abort),
    .i_start_addr   (start_addr),
    .i_sample_count (sample_count),
    .bus            (bus.master),
    .o_readback_idle(idle),
    .o_readback_done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_rd_en) begin
      bus.ram_rd_data <= mem[bus.ram_rd_addr];
      rd_q.push_back(int'(bus.ram_rd_addr));
    end
  end

  always @(negedge clk)
    if (done) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_has(output int w);
    w = 0;
    while (!bus.has_return_data && w < 12) begin
      tick();
      w++;
    end
  endtask

  task automatic run(input int sa, input int cnt,
                     input int dly);
    int w;
    int d0;
    int bad;
    logic [DW-1:0] v;
    rd_q.delete();
    d0 = done_cnt;
    start_addr = AW'(sa);
    sample_count = (AW+1)'(cnt);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      wait_has(w);
      chk("latency", 64'(w), (i == 0) ? 64'd2 : 64'd3);
      if (!bus.has_return_data) return;
      v = bus.return_data;
      chk("data", v, mem[(sa + i) % DEPTH]);
      for (int d = 0; d < dly; d++) begin
        tick();
        chk("wait_has", bus.has_return_data, 1);
        chk("wait_stable", bus.return_data, v);
      end
      bus.get_return_data = 1'b1;
      tick();
      bus.get_return_data = 1'b0;
      chk("hold_has", bus.has_return_data, 0);
      chk("hold_data", bus.return_data, v);
      if (i == cnt - 1) begin
        chk("hold_done", done, 0);
        tick();
        chk("done_pulse", done, 1);
        chk("done_idle", idle, 1);
        tick();
        chk("done_clear", done, 0);
      end
    end
    chk("done_cnt", 64'(done_cnt - d0), 1);
    chk("rd_cnt", 64'(rd_q.size()), 64'(cnt));
    bad = 0;
    for (int i = 0; i < rd_q.size(); i++)
      if (rd_q[i] != (sa + i) % DEPTH) bad++;
    chk("rd_addrs", 64'(bad), 0);
  endtask

  initial begin
    int w;
    int d0;
    logic [DW-1:0] v;
    bus.get_return_data = 1'b0;
    bus.ram_rd_data = '0;
    for (int a = 0; a < DEPTH; a++) mem[a] = $urandom;

    tick();
    tick();
    chk("rst_idle", idle, 1);
    chk("rst_has", bus.has_return_data, 0);
    chk("rst_rden", bus.ram_rd_en, 0);
    chk("rst_addr", bus.ram_rd_addr, 0);
    chk("rst_data", bus.return_data, 0);
    chk("rst_done", done, 0);
    reset_n = 1'b1;
    tick();

    run(32'h005, 3, 0);
    run(32'h3FE, 4, 0);

    for (int a = 0; a < DEPTH; a++)
      mem[a] = DW'(a) * 32'h0001_0001;
    run(32'h100, 2, 20);

    // empty readback
    rd_q.delete();
    d0 = done_cnt;
    sample_count = '0;
    start_addr = AW'(7);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_idle", idle, 1);
    tick();
    chk("zero_clear", done, 0);
    tick();
    tick();
    chk("zero_idle2", idle, 1);
    chk("zero_rd", 64'(rd_q.size()), 0);
    chk("zero_dcnt", 64'(done_cnt - d0), 1);

    for (int a = 0; a < DEPTH; a++) mem[a] = $urandom;

    // abort while presenting, 5 still to go
    rd_q.delete();
    d0 = done_cnt;
    start_addr = AW'(16);
    sample_count = (AW+1)'(6);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_has(w);
    chk("ab_has", bus.has_return_data, 1);
    v = bus.return_data;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_idle", idle, 1);
    chk("ab_has0", bus.has_return_data, 0);
    chk("ab_rden", bus.ram_rd_en, 0);
    chk("ab_keep", bus.return_data, v);
    for (int k = 0; k < 5; k++) tick();
    chk("ab_nodone", 64'(done_cnt - d0), 0);
    chk("ab_rd", 64'(rd_q.size()), 1);
    run(32'h200, 2, 0);

    // abort beats start
    rd_q.delete();
    d0 = done_cnt;
    start_addr = AW'(80);
    sample_count = (AW+1)'(3);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("as_idle", idle, 1);
    tick();
    tick();
    tick();
    chk("as_rd", 64'(rd_q.size()), 0);
    chk("as_done", 64'(done_cnt - d0), 0);

    // reset mid-HOLD with a start during reset
    start_addr = AW'(32);
    sample_count = (AW+1)'(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_has(w);
    bus.get_return_data = 1'b1;
    tick();
    bus.get_return_data = 1'b0;
    chk("rh_hold", bus.has_return_data, 0);
    reset_n = 1'b0;
    start = 1'b1;
    tick();
    reset_n = 1'b1;
    start = 1'b0;
    rd_q.delete();
    d0 = done_cnt;
    chk("rh_idle", idle, 1);
    chk("rh_has", bus.has_return_data, 0);
    chk("rh_rden", bus.ram_rd_en, 0);
    chk("rh_addr", bus.ram_rd_addr, 0);
    chk("rh_data", bus.return_data, 0);
    chk("rh_done", done, 0);
    for (int k = 0; k < 4; k++) tick();
    chk("rh_rd", 64'(rd_q.size()), 0);
    chk("rh_idle2", idle, 1);
    chk("rh_dcnt", 64'(done_cnt - d0), 0);

    for (int r = 0; r < 3; r++)
      run(int'($urandom_range(DEPTH - 1, 0)),
          int'($urandom_range(20, 1)),
          int'($urandom_range(3, 0)));

    run(int'($urandom_range(DEPTH - 1, 0)), DEPTH, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
